pet_timing_gen: RTL and testbench

- Master timing generator for the PET clone.
- Divides the system clock into one fixed 64-cycle frame, which equals one 1 MHz CPU cycle at 64 MHz.
- From that frame it derives:
  - 16 MHz and 8 MHz pixel clock enables,
  - the 6502 CPU clock, bus-enable and data strobe,
  - video shift-register load strobes,
  - the bus-arbitration grant schedule.
- Sits at the top of the design; video, CRTC registers, bus arbiter and CPU interface all consume its strobes.

---
 rtl/pet_timing_gen.sv | 127 ++++++++++++
 tb/tb_pet_timing_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pet_timing_gen.sv
// pet_timing_gen: master 64-cycle frame timing generator for the PET clone.
// Derives pixel enables, 6502 phi2/bus enable/data strobe, video shift-register
// load strobes and the bus-arbitration grant schedule from a 6-bit phase counter.
// Optional macro TIMING_PHASE_DEBUG_EN adds a phase_o port exposing the phase.
module pet_timing_gen #(
    parameter int unsigned SYS_CLOCK_MHZ = 64
) (
    input  logic       sys_clock_i,
    input  logic       sys_reset_n_i,
    output logic       clk16_en_o,
    output logic       clk8_en_o,
    output logic       cpu_be_o,
    output logic       cpu_clock_o,
    output logic       cpu_data_strobe_o,
    output logic       load_sr1_o,
    output logic       load_sr2_o,
    output logic [1:0] grant_o,
    output logic       grant_valid_o
`ifdef TIMING_PHASE_DEBUG_EN
    ,
    output logic [5:0] phase_o
`endif
);

    localparam int unsigned PHASE_W   = 6;
    localparam int unsigned GRANT_W   = 2;
    localparam logic [PHASE_W-1:0] PHASE_RST  = PHASE_W'(63);
    localparam logic [PHASE_W-1:0] PHASE_DS   = PHASE_W'(60);
    localparam logic [PHASE_W-1:0] PHASE_SR1  = PHASE_W'(15);
    localparam logic [PHASE_W-1:0] PHASE_SR2  = PHASE_W'(47);
    localparam logic [GRANT_W-1:0] GRANT_WB   = GRANT_W'(0);
    localparam logic [GRANT_W-1:0] GRANT_VID  = GRANT_W'(1);
    localparam logic [GRANT_W-1:0] GRANT_CPU  = GRANT_W'(2);

    // The frame decode assumes 64 sys cycles per 1 MHz CPU cycle.
    if (SYS_CLOCK_MHZ != 64) begin : g_bad_clock
        $fatal(1, "pet_timing_gen: only SYS_CLOCK_MHZ = 64 is supported");
    end

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    logic               clk16_en_d;
    logic               clk8_en_d;
    logic               cpu_be_d;
    logic               cpu_clock_d;
    logic               cpu_data_strobe_d;
    logic               load_sr1_d;
    logic               load_sr2_d;
    logic [GRANT_W-1:0] grant_d;
    logic               grant_valid_d;

    // Phase register; reset to 63 so the first edge after release yields 0.
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            phase_q <= PHASE_RST;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Next phase: free-running modulo-64 increment.
    always_comb begin
        phase_d = phase_q + PHASE_W'(1);
    end

    // Decode of the next phase so registered outputs line up with phase_q.
    always_comb begin
        clk16_en_d        = 1'b0;
        clk8_en_d         = 1'b0;
        cpu_be_d          = 1'b0;
        cpu_clock_d       = 1'b0;
        cpu_data_strobe_d = 1'b0;
        load_sr1_d        = 1'b0;
        load_sr2_d        = 1'b0;
        grant_d           = GRANT_WB;
        grant_valid_d     = 1'b0;

        clk16_en_d        = (phase_d[1:0] == 2'b11);
        clk8_en_d         = (phase_d[2:0] == 3'b111);
        cpu_clock_d       = phase_d[5];
        cpu_data_strobe_d = (phase_d == PHASE_DS);
        load_sr1_d        = (phase_d == PHASE_SR1);
        load_sr2_d        = (phase_d == PHASE_SR2);
        grant_valid_d     = (phase_d[2:0] == 3'b000);

        if (phase_d[5]) begin
            grant_d = GRANT_CPU;
        end else if (phase_d[4]) begin
            grant_d = GRANT_WB;
        end else begin
            grant_d = GRANT_VID;
        end
        cpu_be_d = (grant_d == GRANT_CPU);
    end

    // Output registers; cleared asynchronously while reset is asserted.
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            clk16_en_o        <= 1'b0;
            clk8_en_o         <= 1'b0;
            cpu_be_o          <= 1'b0;
            cpu_clock_o       <= 1'b0;
            cpu_data_strobe_o <= 1'b0;
            load_sr1_o        <= 1'b0;
            load_sr2_o        <= 1'b0;
            grant_o           <= GRANT_WB;
            grant_valid_o     <= 1'b0;
        end else begin
            clk16_en_o        <= clk16_en_d;
            clk8_en_o         <= clk8_en_d;
            cpu_be_o          <= cpu_be_d;
            cpu_clock_o       <= cpu_clock_d;
            cpu_data_strobe_o <= cpu_data_strobe_d;
            load_sr1_o        <= load_sr1_d;
            load_sr2_o        <= load_sr2_d;
            grant_o           <= grant_d;
            grant_valid_o     <= grant_valid_d;
        end
    end

`ifdef TIMING_PHASE_DEBUG_EN
    // Debug view of the phase register itself.
    assign phase_o = phase_q;
`endif

endmodule

// File: tb/tb_pet_timing_gen.sv
// tb_pet_timing_gen: self-checking bench for pet_timing_gen.
// Reference model derives every output from the frame phase by plain arithmetic.
module tb_pet_timing_gen;

    logic       clk;
    logic       rst_n;
    logic       clk16_en;
    logic       clk8_en;
    logic       cpu_be;
    logic       cpu_clock;
    logic       cpu_data_strobe;
    logic       load_sr1;
    logic       load_sr2;
    logic [1:0] grant;
    logic       grant_valid;
`ifdef TIMING_PHASE_DEBUG_EN
    logic [5:0] phase;
`endif

    pet_timing_gen #(.SYS_CLOCK_MHZ(64)) dut (
        .sys_clock_i      (clk),
        .sys_reset_n_i    (rst_n),
        .clk16_en_o       (clk16_en),
        .clk8_en_o        (clk8_en),
        .cpu_be_o         (cpu_be),
        .cpu_clock_o      (cpu_clock),
        .cpu_data_strobe_o(cpu_data_strobe),
        .load_sr1_o       (load_sr1),
        .load_sr2_o       (load_sr2),
        .grant_o          (grant),
        .grant_valid_o    (grant_valid)
`ifdef TIMING_PHASE_DEBUG_EN
        ,
        .phase_o          (phase)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         p;
        logic       c16;
        logic       c8;
        logic       be;
        logic       cpu;
        logic       ds;
        logic       l1;
        logic       l2;
        logic [1:0] g;
        logic       gv;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    int mp  = 63;
    int cyc = 0;

    // Pulse counters and edge timing
    bit counting = 1'b0;
    int cnt16 = 0, cnt8 = 0, cntds = 0, cntl1 = 0, cntl2 = 0, cntgv = 0;
    bit prev_cpu = 1'b0;
    int last_rise = -1;
    int last_ds   = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d phase %0d)", name, act, exp, cyc, mp);
        end
    endtask

    // Spec-level model: outputs as a function of frame phase.
    function automatic vec_t model(input int p, input bit in_rst);
        vec_t v;
        v.p = p;
        if (in_rst) begin
            v.c16 = 0; v.c8 = 0; v.be = 0; v.cpu = 0; v.ds = 0;
            v.l1 = 0; v.l2 = 0; v.g = 2'b00; v.gv = 0;
        end else begin
            v.c16 = (p % 4 == 3);
            v.c8  = (p % 8 == 7);
            v.cpu = (p >= 32);
            v.g   = (p < 16) ? 2'b01 : ((p < 32) ? 2'b00 : 2'b10);
            v.be  = (v.g == 2'b10);
            v.ds  = (p == 60);
            v.l1  = (p == 15);
            v.l2  = (p == 47);
            v.gv  = (p % 8 == 0);
        end
        return v;
    endfunction

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, ".clk16_en"}, int'(clk16_en), int'(e.c16));
        chk({tag, ".clk8_en"}, int'(clk8_en), int'(e.c8));
        chk({tag, ".cpu_be"}, int'(cpu_be), int'(e.be));
        chk({tag, ".cpu_clock"}, int'(cpu_clock), int'(e.cpu));
        chk({tag, ".cpu_data_strobe"}, int'(cpu_data_strobe), int'(e.ds));
        chk({tag, ".load_sr1"}, int'(load_sr1), int'(e.l1));
        chk({tag, ".load_sr2"}, int'(load_sr2), int'(e.l2));
        chk({tag, ".grant"}, int'(grant), int'(e.g));
        chk({tag, ".grant_valid"}, int'(grant_valid), int'(e.gv));
        chk({tag, ".grant_not_11"}, int'(grant == 2'b11), 0);
        chk({tag, ".be_excl"}, int'(cpu_be), int'(grant == 2'b10));
        if (load_sr1 || load_sr2) chk({tag, ".load_align_c8"}, int'(clk8_en), 1);
        if (clk8_en) chk({tag, ".c8_align_c16"}, int'(clk16_en), 1);
`ifdef TIMING_PHASE_DEBUG_EN
        chk({tag, ".phase"}, int'(phase), rst_n ? e.p : 63);
`endif
    endtask

    // One clock: advance model at the edge, check at the following negedge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) mp = 63;
        else        mp = (mp + 1) % 64;
        cyc++;
        @(negedge clk);
        check_outputs("model", model(mp, !rst_n));
        if (counting) begin
            cnt16 += int'(clk16_en);
            cnt8  += int'(clk8_en);
            cntds += int'(cpu_data_strobe);
            cntl1 += int'(load_sr1);
            cntl2 += int'(load_sr2);
            cntgv += int'(grant_valid);
        end
        if (cpu_clock && !prev_cpu) begin
            if (last_rise >= 0) chk("cpu_period", cyc - last_rise, 64);
            last_rise = cyc;
            last_ds   = -1;
        end
        if (cpu_data_strobe && last_rise >= 0) begin
            chk("ds_after_rise", cyc - last_rise, 28);
            last_ds = cyc;
        end
        if (!cpu_clock && prev_cpu && last_rise >= 0) begin
            chk("cpu_high_len", cyc - last_rise, 32);
            if (last_ds >= 0) chk("ds_before_fall", cyc - last_ds, 4);
        end
        prev_cpu = cpu_clock;
    endtask

    // Assert reset between edges and confirm the asynchronous clear.
    task automatic async_reset(input int dly, input string tag);
        #(dly);
        rst_n     = 1'b0;
        prev_cpu  = 1'b0;
        last_rise = -1;
        last_ds   = -1;
        #1;
        check_outputs(tag, model(63, 1'b1));
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[1]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[2]  = '{7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[3]  = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[4]  = '{15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
        tbl[5]  = '{16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[6]  = '{31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[7]  = '{32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
        tbl[8]  = '{47, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
        tbl[9]  = '{56, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
        tbl[10] = '{60, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[11] = '{63, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};

        // Reset held for 10 cycles
        rst_n = 1'b0;
        #1;
        check_outputs("reset0", model(63, 1'b1));
        for (int i = 0; i < 10; i++) step();

        // Release between edges; first frame checked against the table too
        rst_n    = 1'b1;
        counting = 1'b1;
        for (int c = 0; c < 640; c++) begin
            step();
            if (c == 0) begin
                chk("first_grant", int'(grant), 1);
                chk("first_grant_valid", int'(grant_valid), 1);
                chk("first_cpu_clock", int'(cpu_clock), 0);
            end
            if (c < 64) begin
                for (int k = 0; k < 12; k++)
                    if (tbl[k].p == c) check_outputs("table", tbl[k]);
            end
        end
        counting = 1'b0;
        chk("count_clk16", cnt16, 160);
        chk("count_clk8", cnt8, 80);
        chk("count_ds", cntds, 10);
        chk("count_sr1", cntl1, 10);
        chk("count_sr2", cntl2, 10);
        chk("count_gv", cntgv, 80);

        // Mid-frame reset at phase 40
        begin
            int guard;
            guard = 0;
            while (mp != 40 && guard < 200) begin
                step();
                guard++;
            end
            chk("reach_p40", mp, 40);
        end
        async_reset(2, "midreset");
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();
        chk("restart_phase", mp, 0);
        chk("restart_grant", int'(grant), 1);
        chk("restart_gv", int'(grant_valid), 1);

        // Randomized run lengths and reset pulses
        for (int it = 0; it < 8; it++) begin
            int n;
            int hold;
            n    = int'($urandom_range(1, 150));
            hold = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) step();
            async_reset(int'($urandom_range(1, 3)), "randreset");
            for (int i = 0; i < hold; i++) step();
            rst_n = 1'b1;
            for (int i = 0; i < 70; i++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
